// File: rtl/fetch_pkg.sv
// Shared widths, the NOP encoding and the fetch queue entry layout for the
// instruction fetch stage.
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: synchronous FIFO of {pc, instr} entries with clear.
// Pointers carry an extra MSB so full and empty are distinguishable.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  fetch_entry_t           i_wdata,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_push && !o_full && !i_clear;
    assign w_pop  = i_pop && !o_empty && !i_clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order queue,
// flush/redirect on taken branch. FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               QDEPTH   = 4,
    parameter logic [PC_W-1:0]  RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               is_branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushes
`endif
);

    localparam int           CW         = $clog2(QDEPTH) + 1;
    localparam logic [CW:0]  QDEPTH_LIM = (CW+1)'(QDEPTH);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_ret_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic            w_full;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_issue;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;

    // Credits use the registered count, so a same-cycle pop never frees one.
    assign w_issue = !reset && !is_branch_taken &&
                     (({1'b0, r_outstanding} + {1'b0, w_count}) < QDEPTH_LIM);
    // Acks with nothing outstanding belong to requests issued before reset.
    assign w_ack   = imem_ack && (r_outstanding != '0);
    assign w_push  = w_ack && !is_branch_taken && (r_drop_cnt == '0) && !w_full;
    assign w_pop   = !w_empty && !stall && !is_branch_taken;

    assign w_push_entry.pc    = r_ret_pc;
    assign w_push_entry.instr = imem_rdata;

    fetch_queue #(
        .DEPTH   (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .i_reset (reset),
        .i_clear (is_branch_taken),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_ret_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (is_branch_taken) begin
                r_pc       <= branch_target;
                r_ret_pc   <= branch_target;
                r_drop_cnt <= r_outstanding - CW'(w_ack);
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + PC_W'(1);
                end
                // Dropped words belong to the pre-redirect stream and do not advance ret_pc.
                if (w_ack) begin
                    if (r_drop_cnt != '0) begin
                        r_drop_cnt <= r_drop_cnt - CW'(1);
                    end else begin
                        r_ret_pc <= r_ret_pc + PC_W'(1);
                    end
                end
            end
            case ({w_issue, w_ack})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc    = w_empty ? '0 : w_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != 16'hFFFF)) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if (is_branch_taken && (r_perf_flushes != 16'hFFFF)) begin
                r_perf_flushes <= r_perf_flushes + 16'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
`endif

endmodule
